// File: rtl/dsky_keypad_encoder.sv
// DSKY 4x5 keypad scanner: column scan, frame-level debounce, keycode translation and a
// one-entry valid/ack holding register toward the AGC core. PRO is reported as a raw level.
module dsky_keypad_encoder #(
    parameter int unsigned SCAN_DIV = 16,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    output logic [4:0] col_out,
    input  logic [3:0] row_in,
    output logic [4:0] keycode,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       overrun,
    output logic       pro_held
);

    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE);
    localparam int unsigned PRO_IDX = 18;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StPress   = 2'd1;
    localparam logic [1:0] StHeld    = 2'd2;
    localparam logic [1:0] StRelease = 2'd3;

    logic [4:0]    col_q, col_d;
    logic [2:0]    col_idx_q, col_idx_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [18:0]   frame_q, frame_d, frame_cur;
    logic [1:0]    state_q, state_d;
    logic [4:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [4:0]    keycode_q, keycode_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
    logic          pro_q, pro_d;

    logic [1:0] n_keys;
    logic [4:0] one_idx;
    logic [4:0] accept_idx;
    logic       accept;
    logic       frame_end;
    logic       ack_fire;

    function automatic logic [4:0] key_to_code(input logic [4:0] k);
        case (k)
            5'd0:    key_to_code = 5'd1;
            5'd1:    key_to_code = 5'd2;
            5'd2:    key_to_code = 5'd3;
            5'd3:    key_to_code = 5'd17;
            5'd4:    key_to_code = 5'd31;
            5'd5:    key_to_code = 5'd4;
            5'd6:    key_to_code = 5'd5;
            5'd7:    key_to_code = 5'd6;
            5'd8:    key_to_code = 5'd26;
            5'd9:    key_to_code = 5'd27;
            5'd10:   key_to_code = 5'd7;
            5'd11:   key_to_code = 5'd8;
            5'd12:   key_to_code = 5'd9;
            5'd13:   key_to_code = 5'd16;
            5'd14:   key_to_code = 5'd30;
            5'd15:   key_to_code = 5'd28;
            5'd16:   key_to_code = 5'd18;
            5'd17:   key_to_code = 5'd25;
            default: key_to_code = 5'd0;
        endcase
    endfunction

    // Frame image with the currently driven column's rows merged in; the spare key is not stored.
    always_comb begin
        int idx;
        frame_cur = frame_q;
        for (int r = 0; r < 4; r++) begin
            idx = r * 5 + int'(col_idx_q);
            if (idx < 19) frame_cur[idx] = ~row_in[r];
        end
    end

    always_comb begin
        n_keys  = 2'd0;
        one_idx = 5'd0;
        for (int i = 0; i < 18; i++) begin
            if (frame_cur[i]) begin
                if (n_keys == 2'd0) one_idx = 5'(i);
                n_keys = (n_keys == 2'd0) ? 2'd1 : 2'd2;
            end
        end
    end

    assign frame_end = (col_q != 5'b11111) && (dwell_q == DWELL_LAST) && (col_idx_q == 3'd4);
    assign cnt_inc   = cnt_q + CW'(1);
    assign ack_fire  = valid_q && key_ack;

    always_comb begin
        col_d      = col_q;
        col_idx_d  = col_idx_q;
        dwell_d    = dwell_q;
        frame_d    = frame_q;
        state_d    = state_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        keycode_d  = keycode_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        pro_d      = pro_q;
        accept     = 1'b0;
        accept_idx = cand_q;

        if (col_q == 5'b11111) begin
            col_d     = 5'b11110;
            col_idx_d = 3'd0;
            dwell_d   = '0;
        end else if (dwell_q == DWELL_LAST) begin
            dwell_d   = '0;
            frame_d   = frame_cur;
            col_d     = {col_q[3:0], col_q[4]};
            col_idx_d = (col_idx_q == 3'd4) ? 3'd0 : col_idx_q + 3'd1;
        end else begin
            dwell_d = dwell_q + DW'(1);
        end

        if (frame_end) begin
            pro_d = frame_cur[PRO_IDX];
            case (state_q)
                StIdle: begin
                    if (n_keys == 2'd1) begin
                        cand_d = one_idx;
                        cnt_d  = CW'(1);
                        if (DEBOUNCE == 1) begin
                            accept     = 1'b1;
                            accept_idx = one_idx;
                            state_d    = StHeld;
                        end else begin
                            state_d = StPress;
                        end
                    end
                end
                StPress: begin
                    if (n_keys == 2'd1) begin
                        if (one_idx == cand_q) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc == CNT_DONE) begin
                                accept  = 1'b1;
                                state_d = StHeld;
                            end
                        end else begin
                            cand_d = one_idx;
                            cnt_d  = CW'(1);
                        end
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                StHeld: begin
                    if (n_keys == 2'd0) begin
                        if (DEBOUNCE == 1) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else begin
                            state_d = StRelease;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                default: begin
                    if (n_keys == 2'd0) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end
                    end else begin
                        state_d = StHeld;
                    end
                end
            endcase
        end

        // An ack on the accept edge frees the slot, so the new key loads without overrun.
        if (ack_fire) valid_d = 1'b0;
        if (accept) begin
            if (!valid_q || ack_fire) begin
                keycode_d = key_to_code(accept_idx);
                valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q     <= 5'b11111;
            col_idx_q <= 3'd0;
            dwell_q   <= '0;
            frame_q   <= '0;
            state_q   <= StIdle;
            cand_q    <= 5'd0;
            cnt_q     <= '0;
            keycode_q <= 5'd0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            pro_q     <= 1'b0;
        end else if (ena) begin
            col_q     <= col_d;
            col_idx_q <= col_idx_d;
            dwell_q   <= dwell_d;
            frame_q   <= frame_d;
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            keycode_q <= keycode_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            pro_q     <= pro_d;
        end
    end

    assign col_out   = ena ? col_q : 5'b11111;
    assign keycode   = keycode_q;
    assign key_valid = valid_q;
    assign overrun   = overrun_q;
    assign pro_held  = pro_q;

endmodule

// File: tb/tb_dsky_keypad_encoder.sv
// Bench for dsky_keypad_encoder: a key-matrix model drives row_in from col_out, and a
// frame-timing model plus a keycode queue supply the expected results.
module tb_dsky_keypad_encoder;

    localparam int SCAN_DIV = 16;
    localparam int DEBOUNCE = 4;
    localparam int FRAME    = 5 * SCAN_DIV;

    localparam int K1 = 0, K5 = 6, KVERB = 3, KNOUN = 4, K7 = 10, K9 = 12;
    localparam int KCLR = 14, KENTR = 15, KPRO = 18;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [4:0] col_out;
    logic [3:0] row_in;
    logic [4:0] keycode;
    logic       key_valid;
    logic       key_ack;
    logic       overrun;
    logic       pro_held;

    logic [19:0] keys;
    logic [4:0]  exp_q[$];
    logic [4:0]  exp_code;
    int          edge_cnt;
    int          checks = 0;
    int          errors = 0;

    dsky_keypad_encoder #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .col_out  (col_out),
        .row_in   (row_in),
        .keycode  (keycode),
        .key_valid(key_valid),
        .key_ack  (key_ack),
        .overrun  (overrun),
        .pro_held (pro_held)
    );

    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_in = 4'b1111;
        for (int c = 0; c < 5; c++)
            if (!col_out[c])
                for (int r = 0; r < 4; r++)
                    if (keys[r * 5 + c]) row_in[r] = 1'b0;
    end

    // Enabled edges since reset; edge 1 starts column 0, frames end every FRAME edges after.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else if (ena) edge_cnt <= edge_cnt + 1;
    end

    task automatic wait_frames(input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            do begin
                @(posedge clk);
                #1;
                guard++;
            end while (!(edge_cnt > 1 && (edge_cnt - 1) % FRAME == 0) && guard < 2 * FRAME);
            if (guard >= 2 * FRAME) begin
                errors++;
                $display("FAIL frame_wait: no frame end within %0d cycles", guard);
            end
        end
    endtask

    task automatic ack_and_release();
        key_ack = 1'b1;
        keys    = '0;
        @(posedge clk);
        #1;
        key_ack = 1'b0;
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_clear: key_valid=%b required 0", key_valid);
        end
        wait_frames(DEBOUNCE);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        ena     = 1'b1;
        keys    = '0;
        key_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (col_out !== 5'b11111) begin
            errors++; $display("FAIL rst_col: col_out=%b required 11111", col_out);
        end
        if (keycode !== 5'd0) begin
            errors++; $display("FAIL rst_keycode: keycode=%0d required 0", keycode);
        end
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL rst_valid: key_valid=%b required 0", key_valid);
        end
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL rst_overrun: overrun=%b required 0", overrun);
        end
        if (pro_held !== 1'b0) begin
            errors++; $display("FAIL rst_pro: pro_held=%b required 0", pro_held);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (col_out !== 5'b11110) begin
            errors++; $display("FAIL first_col: col_out=%b required 11110", col_out);
        end
    endtask

    task automatic test_single_press();
        keys[K5] = 1'b1;
        exp_q.push_back(5'd5);
        wait_frames(DEBOUNCE - 1);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL press5_early: key_valid=%b required 0", key_valid);
        end
        wait_frames(1);
        exp_code = exp_q.pop_front();
        checks += 2;
        if (key_valid !== 1'b1) begin
            errors++; $display("FAIL press5_valid: key_valid=%b required 1", key_valid);
        end
        if (keycode !== exp_code) begin
            errors++; $display("FAIL press5_code: keycode=%0d required %0d", keycode, exp_code);
        end
        wait_frames(2);
        checks += 2;
        if (key_valid !== 1'b1) begin
            errors++; $display("FAIL press5_hold: key_valid=%b required 1", key_valid);
        end
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL press5_repeat: overrun=%b required 0", overrun);
        end
    endtask

    task automatic test_ack_noun();
        int n;
        ack_and_release();
        keys[KNOUN] = 1'b1;
        exp_q.push_back(5'd31);
        n = 0;
        while (key_valid !== 1'b1 && n < 6 * FRAME) begin
            @(posedge clk);
            #1;
            n++;
        end
        exp_code = exp_q.pop_front();
        checks += 2;
        if (key_valid !== 1'b1) begin
            errors++; $display("FAIL noun_valid: key_valid=%b required 1 after %0d cycles", key_valid, n);
        end
        if (keycode !== exp_code) begin
            errors++; $display("FAIL noun_code: keycode=%0d required %0d", keycode, exp_code);
        end
        ack_and_release();
    endtask

    task automatic test_multi();
        keys[K7] = 1'b1;
        keys[K9] = 1'b1;
        wait_frames(8);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL multi_block: key_valid=%b required 0", key_valid);
        end
        keys[K9] = 1'b0;
        exp_q.push_back(5'd7);
        wait_frames(DEBOUNCE - 1);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL multi_early: key_valid=%b required 0", key_valid);
        end
        wait_frames(1);
        exp_code = exp_q.pop_front();
        checks += 2;
        if (key_valid !== 1'b1) begin
            errors++; $display("FAIL multi_valid: key_valid=%b required 1", key_valid);
        end
        if (keycode !== exp_code) begin
            errors++; $display("FAIL multi_code: keycode=%0d required %0d", keycode, exp_code);
        end
        ack_and_release();
    endtask

    task automatic test_overrun();
        keys[KENTR] = 1'b1;
        wait_frames(DEBOUNCE);
        checks++;
        if (key_valid !== 1'b1 || keycode !== 5'd28) begin
            errors++; $display("FAIL entr_accept: valid=%b keycode=%0d required 1/28", key_valid, keycode);
        end
        keys = '0;
        wait_frames(DEBOUNCE);
        keys[KCLR] = 1'b1;
        wait_frames(DEBOUNCE);
        checks += 2;
        if (keycode !== 5'd28 || key_valid !== 1'b1) begin
            errors++; $display("FAIL overrun_keep: valid=%b keycode=%0d required 1/28", key_valid, keycode);
        end
        if (overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_set: overrun=%b required 1", overrun);
        end
        keys = '0;
        do_reset();
        checks++;
        if (overrun !== 1'b0 || key_valid !== 1'b0) begin
            errors++; $display("FAIL overrun_rst: overrun=%b valid=%b required 0/0", overrun, key_valid);
        end
        keys[KENTR] = 1'b1;
        wait_frames(DEBOUNCE);
        keys = '0;
        wait_frames(DEBOUNCE);
        keys[KCLR] = 1'b1;
        exp_q.push_back(5'd30);
        wait_frames(DEBOUNCE - 1);
        repeat (FRAME - 1) @(posedge clk);
        #1;
        key_ack = 1'b1;
        @(posedge clk);
        #1;
        key_ack = 1'b0;
        exp_code = exp_q.pop_front();
        checks += 2;
        if (key_valid !== 1'b1 || keycode !== exp_code) begin
            errors++; $display("FAIL ack_accept: valid=%b keycode=%0d required 1/%0d", key_valid, keycode, exp_code);
        end
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL ack_accept_ovr: overrun=%b required 0", overrun);
        end
        ack_and_release();
    endtask

    task automatic test_pro();
        keys[KPRO] = 1'b1;
        wait_frames(1);
        checks++;
        if (pro_held !== 1'b1) begin
            errors++; $display("FAIL pro_on: pro_held=%b required 1", pro_held);
        end
        wait_frames(DEBOUNCE + 1);
        checks++;
        if (key_valid !== 1'b0 || pro_held !== 1'b1) begin
            errors++; $display("FAIL pro_hold: valid=%b pro_held=%b required 0/1", key_valid, pro_held);
        end
        keys = '0;
        wait_frames(1);
        checks++;
        if (pro_held !== 1'b0) begin
            errors++; $display("FAIL pro_off: pro_held=%b required 0", pro_held);
        end
    endtask

    task automatic test_reset_mid();
        keys[KVERB] = 1'b1;
        wait_frames(2);
        #3;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (col_out !== 5'b11111 || keycode !== 5'd0) begin
            errors++; $display("FAIL async_rst: col_out=%b keycode=%0d required 11111/0", col_out, keycode);
        end
        if (key_valid !== 1'b0 || overrun !== 1'b0 || pro_held !== 1'b0) begin
            errors++; $display("FAIL async_rst_flags: valid=%b ovr=%b pro=%b required 0/0/0",
                               key_valid, overrun, pro_held);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wait_frames(DEBOUNCE - 1);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL verb_early: key_valid=%b required 0", key_valid);
        end
        wait_frames(1);
        checks++;
        if (key_valid !== 1'b1 || keycode !== 5'd17) begin
            errors++; $display("FAIL verb_accept: valid=%b keycode=%0d required 1/17", key_valid, keycode);
        end
        ack_and_release();
    endtask

    task automatic test_ena();
        keys[K1] = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        ena = 1'b0;
        #1;
        checks++;
        if (col_out !== 5'b11111) begin
            errors++; $display("FAIL ena_off_col: col_out=%b required 11111", col_out);
        end
        repeat (50) @(posedge clk);
        #1;
        checks++;
        if (col_out !== 5'b11111 || key_valid !== 1'b0) begin
            errors++; $display("FAIL ena_hold: col_out=%b valid=%b required 11111/0", col_out, key_valid);
        end
        ena = 1'b1;
        #1;
        checks++;
        if (col_out !== 5'b11101) begin
            errors++; $display("FAIL ena_resume_col: col_out=%b required 11101", col_out);
        end
        wait_frames(DEBOUNCE - 1);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL ena_early: key_valid=%b required 0", key_valid);
        end
        wait_frames(1);
        checks++;
        if (key_valid !== 1'b1 || keycode !== 5'd1) begin
            errors++; $display("FAIL ena_accept: valid=%b keycode=%0d required 1/1", key_valid, keycode);
        end
        ack_and_release();
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_ack_noun();
        test_multi();
        test_overrun();
        test_pro();
        test_reset_mid();
        test_ena();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsky_keypad_encoder.md
# dsky_keypad_encoder

Scans a 4x5 DSKY key matrix, debounces it and hands single AGC keycodes to the AGC core through a one-entry valid/ack holding register. It sits between the keypad pins of the `tt_um_cordus_wrapper_agc` wrapper and the AGC core's keyboard input channel. It is the input side of the DSKY, complementing the core's 7-segment display output. PRO is reported as a separate level, as on the real DSKY.

## Interface
- SCAN_DIV, default 16: clock cycles each column is driven (dwell); minimum 2.
- DEBOUNCE, default 4: consecutive identical scan frames needed to accept a press or a release; minimum 1.

- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous and active-low.
- ena, input, 1: design enable. When low, every register holds its value and col_out is forced to 5'b11111.
- col_out, output, 5: column drive, active-low one-hot; registered.
- row_in, input, 4: row sense, active-low; externally pulled up and already synchronised.
- keycode, output, 5: AGC keycode; valid only while key_valid=1.
- key_valid, output, 1: keycode is held for the core.
- key_ack, input, 1: core has consumed the keycode.
- overrun, output, 1: sticky flag; a key was accepted while key_valid was already high.
- pro_held, output, 1: PRO key is pressed, sampled once per frame.

## Operation
- Matrix index is k = row*5 + col.
  - Row 0: 1, 2, 3, VERB, NOUN.
  - Row 1: 4, 5, 6, +, -.
  - Row 2: 7, 8, 9, 0, CLR.
  - Row 3: ENTR, RSET, KEY REL, PRO, spare (ignored).
- Keycodes:
  - Digits 1-9 = 5'd1-5'd9; 0 = 5'd16.
  - VERB = 5'd17, RSET = 5'd18, KEY REL = 5'd25, + = 5'd26, - = 5'd27.
  - ENTR = 5'd28, CLR = 5'd30, NOUN = 5'd31.
- Scan:
  - The column counter cycles 0..4.
  - A frame is 5 dwells (5*SCAN_DIV cycles).
  - The frame ends on the sample edge of column 4.
- Frame classification, counting only the 18 keycode keys (PRO and spare excluded):
  - NONE: zero keys pressed.
  - ONE(k): exactly one key pressed.
  - MULTI: two or more keys pressed.
- State machine, evaluated only at frame end:
  - IDLE:
    - NONE stays in IDLE.
    - ONE(k) goes to PRESS with cand=k, cnt=1.
    - MULTI stays in IDLE.
  - PRESS:
    - ONE(cand): cnt+1.
    - ONE(k≠cand): cand=k, cnt=1.
    - NONE or MULTI: back to IDLE.
    - When cnt reaches DEBOUNCE: accept cand and go to HELD.
  - HELD (no autorepeat):
    - NONE: go to RELEASE with cnt=1.
    - Anything else: stay in HELD.
  - RELEASE:
    - NONE: cnt+1; when cnt reaches DEBOUNCE, go to IDLE.
    - Any key: back to HELD.
  - With DEBOUNCE=1, accept occurs directly from IDLE and release returns directly to IDLE.
- Accept:
  - If key_valid=0: keycode←code(cand), key_valid←1.
  - If key_valid=1: keycode is unchanged, the new key is dropped, overrun←1.
- Handshake:
  - key_valid clears on the first edge where key_valid=1 and key_ack=1.
  - key_ack while key_valid=0 is ignored.
  - If ack and accept fall on the same edge, the new key is loaded (key_valid stays 1), the old key is consumed, and overrun is not set.
- pro_held is loaded at every frame end with PRO's raw sample from that frame; it is not debounced.
- overrun clears only on reset.

## Timing
- Reset values:
  - col_out=5'b11111, keycode=0, key_valid=0, overrun=0, pro_held=0.
  - State IDLE, cnt=0, column 0, dwell counter 0.
- The first enabled edge after reset loads col_out=5'b11110 and starts the column 0 dwell.
- Row sampling:
  - Rows are sampled on the edge ending each dwell, after SCAN_DIV-1 cycles of settling.
  - The same edge advances col_out.
- Accept timing:
  - key_valid and keycode update on the frame-end edge of the DEBOUNCE-th consecutive ONE(k) frame.
  - Press-to-valid latency is between (DEBOUNCE-1)*5*SCAN_DIV+1 and (DEBOUNCE+1)*5*SCAN_DIV cycles, depending on press phase.
- key_valid falls on the edge that samples key_ack=1; one-cycle ack pulses suffice.
- ena low mid-frame:
  - Dwell and frame counters freeze and col_out goes to 11111.
  - On resume, the same column is re-driven with its remaining dwell.
- rst_n asserted mid-debounce or mid-handshake clears everything immediately and asynchronously; a pending keycode is lost.

## Test plan
- Press 5 held for 6 frames (defaults) -> key_valid=1, keycode=5'd5 at the 4th frame end; no second key while held.
- key_valid=1 with a 1-cycle key_ack pulse -> key_valid=0 on the next edge; release for 4 frames, press NOUN -> keycode=5'd31.
- Press 7 and 9 together for 8 frames -> key_valid stays 0; release 9 -> keycode=5'd7 after 4 ONE frames.
- Accept ENTR (28) with no ack, release, press CLR -> keycode stays 28 and overrun=1; same sequence with ack on the accept edge -> keycode=30, overrun=0.
- Hold PRO alone -> pro_held=1 at the next frame end and key_valid stays 0; release -> pro_held=0 one frame later.
- Assert rst_n=0 after 2 frames of VERB, then release reset -> all outputs at reset values and a fresh 4-frame debounce is required; ena=0 for 50 cycles -> col_out=11111 and frame timing resumes unchanged.
